// File: rtl/demux8_reg_pkg.sv
// Shared constants and helpers for the 8-way registered byte distributor.
package demux8_reg_pkg;

   localparam int N_CH = 8;

   // Channel select codes, A is bit 0 of out_valid.
   typedef enum logic [2:0] {
      SEL_A = 3'b000,
      SEL_B = 3'b001,
      SEL_C = 3'b010,
      SEL_D = 3'b011,
      SEL_E = 3'b100,
      SEL_F = 3'b101,
      SEL_G = 3'b110,
      SEL_H = 3'b111
   } chan_sel_e;

   localparam logic [2:0] SEQ_LAST = SEL_H;

   // Next TDM slot, wrapping H back to A.
   function automatic logic [2:0] next_seq(input logic [2:0] cur);
      return (cur == SEQ_LAST) ? 3'b000 : cur + 3'd1;
   endfunction

endpackage

// File: rtl/demux8_reg_if.sv
// Producer/consumer bus of the byte distributor.
// Handshakes: a transfer happens on a rising edge where in_valid & in_ready;
// channel i is consumed on an edge where out_valid[i] & out_ack[i].
// in_ready is combinational and may depend on in_sel, auto_mode and out_ack.
interface demux8_reg_if #(
   parameter int WIDTH = 8
) ();
   logic [WIDTH-1:0] in_data;
   logic [2:0]       in_sel;
   logic             in_valid;
   logic             in_ready;
   logic             auto_mode;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] C;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] E;
   logic [WIDTH-1:0] F;
   logic [WIDTH-1:0] G;
   logic [WIDTH-1:0] H;
   logic [7:0]       out_valid;
   logic [7:0]       out_ack;
   logic [2:0]       seq_sel;
   logic             frame_done;

   // Distributor side.
   modport slave (
      input  in_data, in_sel, in_valid, auto_mode, out_ack,
      output in_ready, A, B, C, D, E, F, G, H, out_valid, seq_sel, frame_done
   );

   // Producer/consumer side.
   modport master (
      output in_data, in_sel, in_valid, auto_mode, out_ack,
      input  in_ready, A, B, C, D, E, F, G, H, out_valid, seq_sel, frame_done
   );
endinterface

// File: rtl/demux8_chan.sv
// One channel holding register with its unconsumed-data flag.
module demux8_chan #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_ack,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_valid
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;

   // Load wins over ack; data is kept after ack, only the flag drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_din;
         r_valid <= 1'b1;
      end else if (i_ack) begin
         r_valid <= 1'b0;
      end
   end

   assign o_dout  = r_data;
   assign o_valid = r_valid;

endmodule

// File: rtl/demux8_reg.sv
// Registered 1-to-8 byte distributor: explicit select or wrapping TDM sequence.
module demux8_reg
   import demux8_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   demux8_reg_if.slave bus
);

   logic [N_CH-1:0]  w_valid;
   logic [N_CH-1:0]  w_load;
   logic [WIDTH-1:0] w_dout [N_CH];
   logic [2:0]       w_dst;
   logic             w_acc;
   logic             w_seq_rise;
   logic [2:0]       r_seq;
   logic             r_auto_prev;
   logic             r_frame_done;

   // Destination: sequence slot in auto mode, explicit select otherwise.
   always_comb begin
      w_dst = bus.auto_mode ? r_seq : bus.in_sel;
   end

   // A full destination may be refilled in the same cycle it is acked.
   assign bus.in_ready = ~w_valid[w_dst] | bus.out_ack[w_dst];
   assign w_acc        = bus.in_valid & bus.in_ready;
   assign w_seq_rise   = bus.auto_mode & ~r_auto_prev;

   // One-hot load strobe for the accepted destination.
   always_comb begin
      w_load = '0;
      if (w_acc) begin
         w_load[w_dst] = 1'b1;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      demux8_chan #(.WIDTH(WIDTH)) u_chan (
         .clk     (clk),
         .rst     (rst),
         .i_load  (w_load[g]),
         .i_din   (bus.in_data),
         .i_ack   (bus.out_ack[g]),
         .o_dout  (w_dout[g]),
         .o_valid (w_valid[g])
      );
   end

   // Sequence counter, auto-mode history and end-of-frame pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seq        <= 3'b000;
         r_auto_prev  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_auto_prev  <= bus.auto_mode;
         r_frame_done <= w_acc & bus.auto_mode & (r_seq == SEQ_LAST);
         if (w_seq_rise) begin
            r_seq <= 3'b000;
         end else if (bus.auto_mode & w_acc) begin
            r_seq <= next_seq(r_seq);
         end
      end
   end

   assign bus.A          = w_dout[SEL_A];
   assign bus.B          = w_dout[SEL_B];
   assign bus.C          = w_dout[SEL_C];
   assign bus.D          = w_dout[SEL_D];
   assign bus.E          = w_dout[SEL_E];
   assign bus.F          = w_dout[SEL_F];
   assign bus.G          = w_dout[SEL_G];
   assign bus.H          = w_dout[SEL_H];
   assign bus.out_valid  = w_valid;
   assign bus.seq_sel    = r_seq;
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_demux8_reg.sv
// Directed bench for demux8_reg with a cycle model and literal spot checks.
module tb_demux8_reg;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   bit   chk_en;

   demux8_reg_if #(.WIDTH(8)) bus ();

   demux8_reg #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DUT channels as an array
   logic [7:0] dut_ch [8];
   always_comb begin
      dut_ch[0] = bus.A;
      dut_ch[1] = bus.B;
      dut_ch[2] = bus.C;
      dut_ch[3] = bus.D;
      dut_ch[4] = bus.E;
      dut_ch[5] = bus.F;
      dut_ch[6] = bus.G;
      dut_ch[7] = bus.H;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: channel contents, pending flags, TDM slot, frame pulse
   logic [7:0] m_ch [8];
   bit         m_v [8];
   int         m_seq;
   bit         m_prev;
   bit         m_fd;

   initial begin
      for (int i = 0; i < 8; i++) begin
         m_ch[i] = 8'h00;
         m_v[i]  = 1'b0;
      end
      m_seq  = 0;
      m_prev = 1'b0;
      m_fd   = 1'b0;
   end

   always @(posedge clk) begin
      int dst;
      bit acc;
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            m_ch[i] <= 8'h00;
            m_v[i]  <= 1'b0;
         end
         m_seq  <= 0;
         m_prev <= 1'b0;
         m_fd   <= 1'b0;
      end else begin
         dst = bus.auto_mode ? m_seq : int'(bus.in_sel);
         acc = bus.in_valid && (!m_v[dst] || bus.out_ack[dst]);
         for (int i = 0; i < 8; i++) begin
            if (acc && dst == i) begin
               m_ch[i] <= bus.in_data;
               m_v[i]  <= 1'b1;
            end else if (bus.out_ack[i]) begin
               m_v[i]  <= 1'b0;
            end
         end
         m_fd <= bus.auto_mode && acc && (m_seq == 7);
         if (bus.auto_mode && !m_prev) m_seq <= 0;
         else if (bus.auto_mode && acc) m_seq <= (m_seq + 1) % 8;
         m_prev <= bus.auto_mode;
      end
   end

   // Compare process: every mid-cycle once the DUT has left the unknown state
   always @(negedge clk) begin
      int         d;
      logic [7:0] mv;
      if (chk_en) begin
         mv = 8'h00;
         for (int i = 0; i < 8; i++) mv[i] = m_v[i];
         for (int i = 0; i < 8; i++) chk($sformatf("ch%0d_data", i), 64'(dut_ch[i]), 64'(m_ch[i]));
         chk("out_valid", 64'(bus.out_valid), 64'(mv));
         chk("seq_sel", 64'(bus.seq_sel), 64'(m_seq));
         chk("frame_done", 64'(bus.frame_done), 64'(m_fd));
         d = bus.auto_mode ? m_seq : int'(bus.in_sel);
         chk("in_ready", 64'(bus.in_ready), 64'(!m_v[d] || bus.out_ack[d]));
      end
   end

   // Driver helpers: inputs change 2 time units after the rising edge
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit v, input logic [7:0] d, input logic [2:0] s, input logic [7:0] a);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_sel   = s;
      bus.out_ack  = a;
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      chk_en = 1'b0;
      rst    = 1'b1;
      bus.auto_mode = 1'b0;
      drive(1'b1, 8'hEE, 3'd3, 8'h00);

      // 1: reset held two cycles with in_valid high
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      drive(1'b0, 8'h00, 3'd0, 8'h00);
      @(negedge clk);
      chk("rst_valid", 64'(bus.out_valid), 64'h0);
      chk("rst_seq", 64'(bus.seq_sel), 64'h0);
      chk("rst_ready", 64'(bus.in_ready), 64'h1);
      chk("rst_A", 64'(bus.A), 64'h0);
      chk("rst_H", 64'(bus.H), 64'h0);
      step();

      // 2: manual fill A..H, one new valid bit per cycle
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 8'((i + 1) * 8'h11), 3'(i), 8'h00);
         @(negedge clk);
         chk("man_latency", 64'(bus.out_valid), 64'((1 << i) - 1));
         step();
      end
      drive(1'b0, 8'h00, 3'd0, 8'h00);
      @(negedge clk);
      chk("man_A", 64'(bus.A), 64'h11);
      chk("man_D", 64'(bus.D), 64'h44);
      chk("man_H", 64'(bus.H), 64'h88);
      chk("man_valid", 64'(bus.out_valid), 64'hFF);
      step();

      // 3: backpressure on C, then refill in the ack cycle
      drive(1'b0, 8'h00, 3'd0, 8'hFB);
      step();
      drive(1'b1, 8'h5A, 3'd2, 8'h00);
      @(negedge clk);
      chk("bp_ready0", 64'(bus.in_ready), 64'h0);
      step();
      @(negedge clk);
      chk("bp_ready1", 64'(bus.in_ready), 64'h0);
      chk("bp_C_held", 64'(bus.C), 64'h33);
      step();
      bus.out_ack = 8'h04;
      @(negedge clk);
      chk("bp_ready_ack", 64'(bus.in_ready), 64'h1);
      step();
      drive(1'b0, 8'h00, 3'd0, 8'h00);
      @(negedge clk);
      chk("bp_C", 64'(bus.C), 64'h5A);
      chk("bp_valid", 64'(bus.out_valid), 64'h04);
      chk("bp_seq_hold", 64'(bus.seq_sel), 64'h0);
      step();

      // 4: auto mode frame of nine bytes, in_sel scrambled
      drive(1'b0, 8'h00, 3'd0, 8'hFF);
      step();
      bus.out_ack   = 8'h00;
      bus.auto_mode = 1'b1;
      step();
      for (int k = 0; k < 9; k++) begin
         drive(1'b1, 8'(k), 3'(7 - k), (k == 8) ? 8'h01 : 8'h00);
         @(negedge clk);
         if (k == 8) chk("auto_fd_pulse", 64'(bus.frame_done), 64'h1);
         step();
      end
      drive(1'b0, 8'h00, 3'd0, 8'h00);
      @(negedge clk);
      chk("auto_fd_end", 64'(bus.frame_done), 64'h0);
      chk("auto_seq", 64'(bus.seq_sel), 64'h1);
      chk("auto_A", 64'(bus.A), 64'h08);
      chk("auto_B", 64'(bus.B), 64'h01);
      chk("auto_H", 64'(bus.H), 64'h07);
      chk("auto_valid", 64'(bus.out_valid), 64'hFF);
      step();

      // 5: simultaneous independent acks
      bus.out_ack = 8'hA5;
      step();
      bus.out_ack = 8'h00;
      @(negedge clk);
      chk("mack_valid", 64'(bus.out_valid), 64'h5A);
      chk("mack_A", 64'(bus.A), 64'h08);
      chk("mack_F", 64'(bus.F), 64'h05);
      step();

      // 6: reset mid-frame, then auto restarts at A
      bus.out_ack = 8'hFF;
      step();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 8'(8'h21 + k), 3'd0, (k == 3) ? 8'h02 : 8'h00);
         step();
      end
      drive(1'b0, 8'h00, 3'd0, 8'h00);
      @(negedge clk);
      chk("mid_seq", 64'(bus.seq_sel), 64'h5);
      chk("mid_valid", 64'(bus.out_valid), 64'h1C);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive(1'b1, 8'h99, 3'd6, 8'h00);
      @(negedge clk);
      chk("mrst_valid", 64'(bus.out_valid), 64'h0);
      chk("mrst_seq", 64'(bus.seq_sel), 64'h0);
      chk("mrst_C", 64'(bus.C), 64'h0);
      step();
      drive(1'b0, 8'h00, 3'd0, 8'h00);
      @(negedge clk);
      chk("mrst_A", 64'(bus.A), 64'h99);
      chk("mrst_valid2", 64'(bus.out_valid), 64'h01);
      chk("mrst_seq2", 64'(bus.seq_sel), 64'h0);
      step();

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
